// File: rtl/ped_walk_controller_pkg.sv
// Shared light/walk encodings for the pedestrian walk controller slice.
package ped_pkg;

   typedef enum logic [1:0] {
      LIGHT_RED     = 2'b00,
      LIGHT_YELLOW  = 2'b01,
      LIGHT_GREEN   = 2'b10,
      LIGHT_ILLEGAL = 2'b11
   } light_e;

   typedef enum logic [1:0] {
      WALK_DONT_WALK = 2'b00,
      WALK_WALK      = 2'b01,
      WALK_FLASH     = 2'b10
   } walk_e;

   function automatic logic light_illegal(input logic [1:0] l);
      return l == LIGHT_ILLEGAL;
   endfunction

endpackage

// File: rtl/ped_walk_controller_channel.sv
// One pedestrian crossing: walk FSM, walk/clear timer, request latch, previous-light register.
// PED_AUTO_RECALL_EN: serve WALK on every green rise, request or not.
module ped_channel
   import ped_pkg::*;
#(
   parameter int unsigned WALK_CYCLES  = 8,
   parameter int unsigned CLEAR_CYCLES = 6,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       light,
   input  logic             btn,
   input  logic             hold,
   output logic [1:0]       walk,
   output logic [CNT_W-1:0] countdown,
   output logic             req_pending
);

   localparam logic [CNT_W-1:0] WALK_INIT  = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_INIT = CNT_W'(CLEAR_CYCLES - 1);

   walk_e            state;
   light_e           cur;
   light_e           prev_light;
   logic [CNT_W-1:0] timer;
   logic             green_rise;
   logic             serve;

   always_comb begin
      cur        = light_e'(light);
      green_rise = (cur == LIGHT_GREEN) && (prev_light != LIGHT_GREEN);
`ifdef PED_AUTO_RECALL_EN
      serve      = green_rise;
`else
      serve      = green_rise && (req_pending || btn);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WALK_DONT_WALK;
         timer       <= '0;
         countdown   <= '0;
         req_pending <= 1'b0;
         prev_light  <= LIGHT_RED;
      end else begin
         prev_light <= cur;
         if (hold) begin
            state       <= WALK_DONT_WALK;
            timer       <= '0;
            countdown   <= '0;
            req_pending <= req_pending | btn;
         end else begin
            case (state)
               WALK_DONT_WALK: begin
                  countdown <= '0;
                  if (serve) begin
                     state       <= WALK_WALK;
                     timer       <= WALK_INIT;
                     req_pending <= 1'b0;
                  end else begin
                     req_pending <= req_pending | btn;
                  end
               end
               WALK_WALK: begin
                  if (cur == LIGHT_RED) begin
                     state     <= WALK_DONT_WALK;
                     timer     <= '0;
                     countdown <= '0;
                  end else if (timer == '0 || cur != LIGHT_GREEN) begin
                     state     <= WALK_FLASH;
                     timer     <= CLEAR_INIT;
                     countdown <= CLEAR_INIT;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               WALK_FLASH: begin
                  req_pending <= req_pending | btn;
                  // countdown shadows the timer so it shows the remaining FLASH clocks
                  if (cur == LIGHT_RED || timer == '0) begin
                     state     <= WALK_DONT_WALK;
                     timer     <= '0;
                     countdown <= '0;
                  end else begin
                     timer     <= timer - 1'b1;
                     countdown <= timer - 1'b1;
                  end
               end
               default: begin
                  state     <= WALK_DONT_WALK;
                  timer     <= '0;
                  countdown <= '0;
               end
            endcase
         end
      end
   end

   assign walk = state;

endmodule

// File: rtl/ped_walk_controller.sv
// Pedestrian WALK/FLASH/DONT_WALK heads for NS and EW, slaved to the vehicle lights.
// PED_AUTO_RECALL_EN (optional macro): every green rise serves WALK without a button request.
module ped_walk_controller
   import ped_pkg::*;
#(
   parameter int unsigned WALK_CYCLES  = 8,
   parameter int unsigned CLEAR_CYCLES = 6,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       ns_light,
   input  logic [1:0]       ew_light,
   input  logic             ped_btn_ns,
   input  logic             ped_btn_ew,
   output logic [1:0]       ns_walk,
   output logic [1:0]       ew_walk,
   output logic [CNT_W-1:0] ns_countdown,
   output logic [CNT_W-1:0] ew_countdown,
   output logic             ns_req_pending,
   output logic             ew_req_pending,
   output logic             fault
);

   logic bad_inputs;
   logic force_dont_walk;

   always_comb begin
      bad_inputs = light_illegal(ns_light) || light_illegal(ew_light) ||
                   (ns_light != LIGHT_RED && ew_light != LIGHT_RED);
      // Forcing on the cycle the fault is detected keeps the channel registers
      // at DONT_WALK on exactly the clocks where the registered fault reads 1.
      force_dont_walk = fault | bad_inputs;
   end

   always_ff @(posedge clk) begin
      if (reset) fault <= 1'b0;
      else       fault <= fault | bad_inputs;
   end

   ped_channel #(
      .WALK_CYCLES (WALK_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES),
      .CNT_W       (CNT_W)
   ) u_ns (
      .clk        (clk),
      .reset      (reset),
      .light      (ns_light),
      .btn        (ped_btn_ns),
      .hold       (force_dont_walk),
      .walk       (ns_walk),
      .countdown  (ns_countdown),
      .req_pending(ns_req_pending)
   );

   ped_channel #(
      .WALK_CYCLES (WALK_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES),
      .CNT_W       (CNT_W)
   ) u_ew (
      .clk        (clk),
      .reset      (reset),
      .light      (ew_light),
      .btn        (ped_btn_ew),
      .hold       (force_dont_walk),
      .walk       (ew_walk),
      .countdown  (ew_countdown),
      .req_pending(ew_req_pending)
   );

endmodule
